// File: rtl/lcd_text_engine.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : lcd_text_engine                                                 |
// | Purpose  : Builds the two LCD text lines from the game state, the player   |
// |            money (sequential binary-to-BCD, leading-zero blanked) and the  |
// |            keypad digits, with a blinking edit cursor and a scrolling      |
// |            clear-message marquee. Lines are registered; frame_upd_o        |
// |            pulses for one cycle whenever either line changes.              |
// | Ports    : clk, rst_n (async, active-low)                                  |
// |            state_i[3:0], current_money_i[MONEY_W-1:0], user_num0..3_i[2:0],|
// |            num_store_idx_i[1:0]                                            |
// |            line1_o/line2_o[8*COLS-1:0] (column 0 in MSBs), frame_upd_o,    |
// |            bcd_busy_o                                                      |
// | Revision : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module lcd_text_engine #(
  parameter int COLS         = 16,
  parameter int MONEY_W      = 16,
  parameter int DIGITS       = 5,
  parameter int MONEY_MAX    = 10000,
  parameter int BLINK_TICKS  = 25_000_000,
  parameter int SCROLL_TICKS = 12_500_000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [3:0]         state_i,
  input  logic [MONEY_W-1:0] current_money_i,
  input  logic [2:0]         user_num0_i,
  input  logic [2:0]         user_num1_i,
  input  logic [2:0]         user_num2_i,
  input  logic [2:0]         user_num3_i,
  input  logic [1:0]         num_store_idx_i,
  output logic [8*COLS-1:0]  line1_o,
  output logic [8*COLS-1:0]  line2_o,
  output logic               frame_upd_o,
  output logic               bcd_busy_o
);

  localparam int BCD_W  = 4*DIGITS;
  localparam int BIT_W  = $clog2(MONEY_W+1);
  // Line-2 scratch buffer: wide enough for the longest composed text.
  localparam int BUF_CH = (DIGITS > 6) ? (DIGITS + 10) : 16;
  localparam int BUF_W  = 8*BUF_CH;
  localparam logic [MONEY_W-1:0] MONEY_CLAMP = MONEY_W'(MONEY_MAX);
  localparam logic [BIT_W-1:0]   LAST_BIT    = BIT_W'(MONEY_W-1);
  localparam logic [31:0]        BLINK_LAST  = 32'(BLINK_TICKS-1);
  localparam logic [31:0]        SCROLL_LAST = 32'(SCROLL_TICKS-1);
  localparam logic [7:0]         SP          = 8'h20;
  localparam logic [255:0]       MARQUEE     = "*** GAME CLEAR - TARGET REACHED ";

  typedef enum logic [1:0] {
    CONV_IDLE = 2'd0,
    CONV_RUN  = 2'd1,
    CONV_DONE = 2'd2
  } conv_state_e;

  // Stage 0 input registers and blink/scroll timers
  logic [3:0]      state_q;
  logic [1:0]      idx_q;
  logic [3:0][2:0] num_q;
  logic [31:0]     blink_cnt_q;
  logic            blink_phase_q;
  logic [31:0]     scroll_cnt_q;
  logic [4:0]      scroll_off_q;
  logic            w_state_chg;

  // Money converter
  conv_state_e        conv_q;
  logic               first_q;
  logic               bcd_busy_q;
  logic [MONEY_W-1:0] last_q;
  logic [MONEY_W-1:0] raw_q;
  logic [MONEY_W-1:0] bin_q;
  logic [BCD_W-1:0]   bcd_q;
  logic [BCD_W-1:0]   digits_q;
  logic [BIT_W-1:0]   bit_q;
  logic [BCD_W-1:0]   w_bcd_adj;

  // Text composition and frame register
  logic [8*DIGITS-1:0] w_money;
  logic [31:0]         w_udig;
  logic [7:0]          w_d0;
  logic [127:0]        w_marq;
  logic [127:0]        w_t1;
  logic [BUF_W-1:0]    w_buf;
  logic [8*COLS-1:0]   w_l1;
  logic [8*COLS-1:0]   w_l2;
  logic [8*COLS-1:0]   line1_q;
  logic [8*COLS-1:0]   line2_q;
  logic                frame_upd_q;

  // The timers are cleared on the same edge that loads a new state, so the
  // first frame of any state always shows phase 0 / offset 0.
  assign w_state_chg = (state_i != state_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= '0;
      idx_q         <= '0;
      num_q         <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      scroll_cnt_q  <= '0;
      scroll_off_q  <= '0;
    end else begin
      state_q <= state_i;
      idx_q   <= num_store_idx_i;
      num_q   <= {user_num3_i, user_num2_i, user_num1_i, user_num0_i};
      if (w_state_chg) begin
        blink_cnt_q   <= '0;
        blink_phase_q <= 1'b0;
        scroll_cnt_q  <= '0;
        scroll_off_q  <= '0;
      end else begin
        if (blink_cnt_q == BLINK_LAST) begin
          blink_cnt_q   <= '0;
          blink_phase_q <= ~blink_phase_q;
        end else begin
          blink_cnt_q <= blink_cnt_q + 32'd1;
        end
        if (scroll_cnt_q == SCROLL_LAST) begin
          scroll_cnt_q <= '0;
          scroll_off_q <= scroll_off_q + 5'd1;
        end else begin
          scroll_cnt_q <= scroll_cnt_q + 32'd1;
        end
      end
    end
  end

  // Double-dabble correction: any BCD digit >= 5 gets +3 before the shift.
  always_comb begin
    w_bcd_adj = bcd_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        w_bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
  end

  // last_q holds the raw (unclamped) sample so an over-range balance does
  // not retrigger conversions forever.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conv_q     <= CONV_IDLE;
      first_q    <= 1'b1;
      bcd_busy_q <= 1'b0;
      last_q     <= '0;
      raw_q      <= '0;
      bin_q      <= '0;
      bcd_q      <= '0;
      digits_q   <= '0;
      bit_q      <= '0;
    end else begin
      case (conv_q)
        CONV_IDLE: begin
          if (first_q || (current_money_i != last_q)) begin
            first_q    <= 1'b0;
            raw_q      <= current_money_i;
            bin_q      <= (current_money_i > MONEY_CLAMP) ? MONEY_CLAMP : current_money_i;
            bcd_q      <= '0;
            bit_q      <= '0;
            bcd_busy_q <= 1'b1;
            conv_q     <= CONV_RUN;
          end
        end
        CONV_RUN: begin
          bcd_q <= {w_bcd_adj[BCD_W-2:0], bin_q[MONEY_W-1]};
          bin_q <= {bin_q[MONEY_W-2:0], 1'b0};
          bit_q <= bit_q + BIT_W'(1);
          if (bit_q == LAST_BIT) begin
            conv_q <= CONV_DONE;
          end
        end
        CONV_DONE: begin
          digits_q   <= bcd_q;
          last_q     <= raw_q;
          bcd_busy_q <= 1'b0;
          conv_q     <= CONV_IDLE;
        end
        default: begin
          bcd_busy_q <= 1'b0;
          conv_q     <= CONV_IDLE;
        end
      endcase
    end
  end

  // Right-aligned money field; leading zeros blank, units digit always shown.
  always_comb begin : money_field
    logic       lead;
    logic [3:0] dig;
    lead    = 1'b1;
    dig     = '0;
    w_money = '0;
    for (int i = DIGITS-1; i >= 0; i--) begin
      dig = digits_q[4*i +: 4];
      if (lead && (dig == 4'd0) && (i != 0)) begin
        w_money[8*i +: 8] = SP;
      end else begin
        w_money[8*i +: 8] = 8'h30 + {4'd0, dig};
        lead = 1'b0;
      end
    end
  end

  // Keypad digits, digit 0 leftmost; the edited one blinks to '_'.
  always_comb begin : user_digits
    logic blink_on;
    blink_on = ((state_q == 4'd1) || (state_q == 4'd3)) && blink_phase_q;
    w_udig   = '0;
    for (int i = 0; i < 4; i++) begin
      w_udig[8*(3-i) +: 8] = (blink_on && (idx_q == 2'(i))) ? 8'h5F
                                                            : (8'h31 + {5'd0, num_q[i]});
    end
    w_d0 = 8'h31 + {5'd0, num_q[0]};
  end

  // Marquee window: column k shows message byte (scroll_off + k) mod 32.
  always_comb begin : marquee
    logic [4:0] pos;
    pos    = '0;
    w_marq = '0;
    for (int k = 0; k < 16; k++) begin
      pos = scroll_off_q + 5'(k);
      w_marq[8*(15-k) +: 8] = MARQUEE[{~pos, 3'b000} +: 8];
    end
  end

  always_comb begin
    w_t1  = {16{SP}};
    w_buf = {BUF_CH{SP}};
    case (state_q)
      4'd0: begin
        w_t1 = "PRESS * TO START";
        w_buf[BUF_W-1 -: 8*(7+DIGITS)] = {"MONEY: ", w_money};
      end
      4'd1: begin
        w_t1 = "BET MONEY (OK)  ";
        w_buf[BUF_W-1 -: 8*(10+DIGITS)] = {"[1~", w_money, "]: ", w_udig};
      end
      4'd2: begin
        w_t1 = "SELECT CNT [1~4]";
        w_buf[BUF_W-1 -: 128] = {"CNT:", w_d0, " OK:* CLR:#"};
      end
      4'd3: begin
        w_t1 = "PICK NUM [1~8]  ";
        w_buf[BUF_W-1 -: 128] = {"INPUT:", w_udig, " CLR:#"};
      end
      4'd4: begin
        w_t1 = "SPIN START!!    ";
        w_buf[BUF_W-1 -: 128] = "GOOD LUCK...!   ";
      end
      4'd5: begin
        w_t1 = "SLOWING DOWN... ";
        w_buf[BUF_W-1 -: 128] = "WAIT A MOMENT..!";
      end
      4'd6: begin
        w_t1 = "RESULT STOP!!   ";
        w_buf[BUF_W-1 -: 128] = "CHECKING...     ";
      end
      4'd7: begin
        w_t1 = "*YOU WIN!!*     ";
        w_buf[BUF_W-1 -: 8*(7+DIGITS)] = {"MONEY: ", w_money};
      end
      4'd8: begin
        w_t1 = "TRY AGAIN...    ";
        w_buf[BUF_W-1 -: 8*(7+DIGITS)] = {"MONEY: ", w_money};
      end
      4'd9: begin
        w_t1 = "UPDATING MONEY  ";
        w_buf[BUF_W-1 -: 128] = "PLEASE WAIT...  ";
      end
      4'd10, 4'd11: begin
        w_t1 = "NEXT ROUND??    ";
        w_buf[BUF_W-1 -: 128] = "PRESS * TO GO!! ";
      end
      4'd12: begin
        w_t1 = "GAME OVER!!     ";
        w_buf[BUF_W-1 -: 128] = "YOU LOST MONEY  ";
      end
      4'd13: begin
        w_t1 = w_marq;
        w_buf[BUF_W-1 -: 8*(9+DIGITS)] = {"MONEY: ", w_money, "!!"};
      end
      default: ;
    endcase
    // Only the first 16 columns ever carry text.
    w_l1 = {COLS{SP}};
    w_l1[8*COLS-1 -: 128] = w_t1;
    w_l2 = {COLS{SP}};
    w_l2[8*COLS-1 -: 128] = w_buf[BUF_W-1 -: 128];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line1_q     <= {COLS{SP}};
      line2_q     <= {COLS{SP}};
      frame_upd_q <= 1'b0;
    end else begin
      line1_q     <= w_l1;
      line2_q     <= w_l2;
      frame_upd_q <= (w_l1 != line1_q) || (w_l2 != line2_q);
    end
  end

  assign line1_o     = line1_q;
  assign line2_o     = line2_q;
  assign frame_upd_o = frame_upd_q;
  assign bcd_busy_o  = bcd_busy_q;

endmodule
`default_nettype wire
